// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce/edge-generator front end.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HI      = 2'd2,
    S_WAIT_LO = 2'd3
  } db_state_t;

  localparam int unsigned DB_SYNC_STAGES = 2;
  localparam int unsigned DB_CYCLES      = 4;
  localparam int unsigned DB_CNT_W       = 8;

endpackage

// File: rtl/debounce_edge_gen_sync_chain.sv
// Plain flop-chain synchronizer with synchronous active-high reset.
// Kept free of logic between stages so it can be reused as a CDC synchronizer.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic x,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through STAGES flops; reset clears the whole chain.
  always_ff @(posedge clk) begin
    if (x) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_edge_gen.sv
// Synchronizes and debounces a raw level, then emits registered one-cycle
// rise/fall pulses on each accepted transition plus a wrapping rise count.
module debounce_edge_gen
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DB_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DB_CYCLES,
  parameter int unsigned CNT_W           = DB_CNT_W
) (
  input  logic             clk,
  input  logic             x,
  input  logic             din,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic             w_s;
  logic             w_level;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [CntW-1:0]  w_cnt_nxt;
  logic             r_rise;
  logic             r_fall;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic [CNT_W-1:0] r_rise_cnt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .x   (x),
    .d   (din),
    .q   (w_s)
  );

  // Accepted level is purely a decode of the state register.
  always_comb begin
    w_level = 1'b0;
    unique case (r_state)
      S_HI, S_WAIT_LO: w_level = 1'b1;
      default:         w_level = 1'b0;
    endcase
  end

  // Stability counting: a run of DEBOUNCE_CYCLES mismatching samples flips the level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (w_s == w_level) begin
      w_cnt_nxt   = '0;
      w_state_nxt = w_level ? S_HI : S_LO;
    end else if (r_cnt < CntLast) begin
      w_cnt_nxt   = r_cnt + CntW'(1);
      w_state_nxt = w_level ? S_WAIT_LO : S_WAIT_HI;
    end else begin
      w_cnt_nxt   = '0;
      w_state_nxt = w_level ? S_LO : S_HI;
      w_rise_nxt  = ~w_level;
      w_fall_nxt  = w_level;
    end
  end

  // State, counter and registered pulses; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (x) begin
      r_state    <= S_LO;
      r_cnt      <= '0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_rise_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      if (w_rise_nxt) begin
        r_rise_cnt <= r_rise_cnt + CNT_W'(1);
      end
    end
  end

  assign level    = w_level;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign rise_cnt = r_rise_cnt;

endmodule
